// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: MEM->WB valid/ready pipeline register for the MIPS core.
// Holds one write-back beat, with stall, flush, $0 masking and a forwarding
// qualifier for the hazard unit.
// Build option: define PIPE_WB_SKID_EN to add a one-entry skid register.
// This gives a capacity of two beats, and in_ready then comes from a flop.
module wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_AW-1:0] in_wr_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [REG_AW-1:0] out_wr_reg,
  output logic [DATA_W-1:0] out_wb_data,
  output logic              fwd_valid
);

  // Write-back source select: load results come from memory, all else from the ALU
  function automatic logic [DATA_W-1:0] wb_select(
    input logic              mem_to_reg,
    input logic [DATA_W-1:0] mem_data,
    input logic [DATA_W-1:0] alu_result
  );
    return mem_to_reg ? mem_data : alu_result;
  endfunction

  logic              main_valid_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] main_mem_r;
  logic [DATA_W-1:0] main_alu_r;
  logic [REG_AW-1:0] main_reg_r;

  logic              xfer_in_s;
  logic              xfer_out_s;
  logic              main_load_s;
  logic              main_valid_nxt_s;
  logic [CTRL_W-1:0] main_ctrl_src_s;
  logic [DATA_W-1:0] main_mem_src_s;
  logic [DATA_W-1:0] main_alu_src_s;
  logic [REG_AW-1:0] main_reg_src_s;
  logic              reg_nonzero_s;
  logic [CTRL_W-1:0] out_ctrl_s;

`ifdef PIPE_WB_SKID_EN
  logic              skid_valid_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [DATA_W-1:0] skid_mem_r;
  logic [DATA_W-1:0] skid_alu_r;
  logic [REG_AW-1:0] skid_reg_r;
  logic              in_ready_r;
  logic              skid_load_s;
  logic              skid_valid_nxt_s;
  logic              from_skid_s;

  assign in_ready = in_ready_r;
`else
  assign in_ready = ~main_valid_r | out_ready;
`endif

  assign xfer_in_s  = in_valid & in_ready;
  assign xfer_out_s = main_valid_r & out_ready;

  // Next-state for the main (and skid) entries; flush discards held and incoming beats
  always_comb begin
    main_load_s      = 1'b0;
    main_valid_nxt_s = main_valid_r;
`ifdef PIPE_WB_SKID_EN
    from_skid_s      = 1'b0;
    skid_load_s      = 1'b0;
    skid_valid_nxt_s = skid_valid_r;
`endif
    if (flush) begin
      main_valid_nxt_s = 1'b0;
`ifdef PIPE_WB_SKID_EN
      skid_valid_nxt_s = 1'b0;
`endif
    end else begin
`ifdef PIPE_WB_SKID_EN
      if (xfer_out_s) begin
        if (skid_valid_r) begin
          // The skid is full, so in_ready is low and no beat is arriving this cycle.
          main_load_s      = 1'b1;
          from_skid_s      = 1'b1;
          main_valid_nxt_s = 1'b1;
          skid_valid_nxt_s = 1'b0;
        end else if (xfer_in_s) begin
          main_load_s      = 1'b1;
          main_valid_nxt_s = 1'b1;
        end else begin
          main_valid_nxt_s = 1'b0;
        end
      end else if (xfer_in_s) begin
        if (main_valid_r) begin
          skid_load_s      = 1'b1;
          skid_valid_nxt_s = 1'b1;
        end else begin
          main_load_s      = 1'b1;
          main_valid_nxt_s = 1'b1;
        end
      end else begin
        main_valid_nxt_s = main_valid_r;
      end
`else
      if (xfer_in_s) begin
        main_load_s      = 1'b1;
        main_valid_nxt_s = 1'b1;
      end else if (xfer_out_s) begin
        main_valid_nxt_s = 1'b0;
      end else begin
        main_valid_nxt_s = main_valid_r;
      end
`endif
    end
  end

  // Choose where the main entry loads from: the skid entry drains ahead of new input
  always_comb begin
    main_ctrl_src_s = in_ctrl;
    main_mem_src_s  = in_mem_data;
    main_alu_src_s  = in_alu_result;
    main_reg_src_s  = in_wr_reg;
`ifdef PIPE_WB_SKID_EN
    if (from_skid_s) begin
      main_ctrl_src_s = skid_ctrl_r;
      main_mem_src_s  = skid_mem_r;
      main_alu_src_s  = skid_alu_r;
      main_reg_src_s  = skid_reg_r;
    end else begin
      main_ctrl_src_s = in_ctrl;
      main_mem_src_s  = in_mem_data;
      main_alu_src_s  = in_alu_result;
      main_reg_src_s  = in_wr_reg;
    end
`endif
  end

  // Main stage register; data fields persist after consumption, only valid drops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_r <= 1'b0;
      main_ctrl_r  <= '0;
      main_mem_r   <= '0;
      main_alu_r   <= '0;
      main_reg_r   <= '0;
    end else begin
      main_valid_r <= main_valid_nxt_s;
      if (main_load_s) begin
        main_ctrl_r <= main_ctrl_src_s;
        main_mem_r  <= main_mem_src_s;
        main_alu_r  <= main_alu_src_s;
        main_reg_r  <= main_reg_src_s;
      end
    end
  end

`ifdef PIPE_WB_SKID_EN
  // Skid entry catches the beat that arrives while main is stalled; in_ready is its flopped inverse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_valid_r <= 1'b0;
      skid_ctrl_r  <= '0;
      skid_mem_r   <= '0;
      skid_alu_r   <= '0;
      skid_reg_r   <= '0;
      in_ready_r   <= 1'b1;
    end else begin
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= ~skid_valid_nxt_s;
      if (skid_load_s) begin
        skid_ctrl_r <= in_ctrl;
        skid_mem_r  <= in_mem_data;
        skid_alu_r  <= in_alu_result;
        skid_reg_r  <= in_wr_reg;
      end
    end
  end
`endif

  assign reg_nonzero_s = (main_reg_r != '0);

  // Mask control: an empty stage presents no control, and $0 is never written or forwarded
  always_comb begin
    out_ctrl_s = '0;
    if (main_valid_r) begin
      out_ctrl_s    = main_ctrl_r;
      out_ctrl_s[0] = main_ctrl_r[0] & reg_nonzero_s;
    end else begin
      out_ctrl_s = '0;
    end
  end

  assign out_valid      = main_valid_r;
  assign out_ctrl       = out_ctrl_s;
  assign out_mem_data   = main_mem_r;
  assign out_alu_result = main_alu_r;
  assign out_wr_reg     = main_reg_r;
  assign out_wb_data    = wb_select(main_ctrl_r[1], main_mem_r, main_alu_r);
  assign fwd_valid      = main_valid_r & out_ctrl_s[0];

endmodule

// File: doc/wb_pipe_reg.md
# wb_pipe_reg

Parametrised MEM→WB pipeline register for the MIPS core, replacing the fixed-width stage register with a valid/ready pipeline stage that supports stall, flush, bubble masking and write-back forwarding. It sits between the data-memory stage and the register-file write port. It captures ALU result, memory read data, destination register and control bits. It presents the selected write-back value plus a forwarding qualifier to the hazard/forwarding unit. An optional one-entry skid buffer breaks the combinational ready path.

## Interface
- DATA_W, 32, width of ALU result and memory data
- REG_AW, 5, destination register index width
- CTRL_W, 2, control field width; bit0 = regWrite, bit1 = memToReg, higher bits passed through
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all held and incoming beats
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_ctrl  in  CTRL_W  control bits from EX/MEM
- in_mem_data  in  DATA_W  data read from memory
- in_alu_result  in  DATA_W  ALU result from EX/MEM
- in_wr_reg  in  REG_AW  destination register
- out_valid  out  1  beat held for write-back
- out_ready  in  1  write-back consumer accepts beat
- out_ctrl  out  CTRL_W  registered control, masked (see Operation)
- out_mem_data, out_alu_result  out  DATA_W  registered data
- out_wr_reg  out  REG_AW  registered destination
- out_wb_data  out  DATA_W  out_ctrl[1] ? out_mem_data : out_alu_result
- fwd_valid  out  1  out_valid & out_ctrl[0]; forwarding unit may use out_wb_data for out_wr_reg

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Main register loads on transfer-in when empty or when emptied by a same-cycle transfer-out. Otherwise it holds.
- Masking: regWrite output bit is 0 when out_valid=0 or out_wr_reg=0; $0 is never written or forwarded. Other out_ctrl bits are 0 when out_valid=0.
- Data fields are not cleared on consumption; only valid and masked ctrl change.
- flush=1: main and skid valid cleared next edge; a beat offered that cycle is dropped. flush overrides in_valid and out_ready. in_ready during flush is unchanged (beat accepted then discarded).
- Simultaneous in/out transfer with main full: new beat replaces old, out_valid stays 1.
- Without skid: in_ready = ~out_valid | out_ready (combinational).

## Timing
- Latency 1 cycle: beat accepted at edge N is visible on outputs after edge N.
- Full throughput: one beat per cycle when out_ready=1 continuously.
- Reset values: out_valid=0, out_ctrl=0, out_mem_data=0, out_alu_result=0, out_wr_reg=0, out_wb_data=0, fwd_valid=0. in_ready=1 immediately after reset deassert. Reset mid-transfer discards all beats.
- out_wb_data and fwd_valid are combinational from registered state only; there is no in→out combinational path.

## Configuration
- PIPE_WB_SKID_EN defined: one-entry skid register added. in_ready is a registered signal equal to ~skid_valid. When main is full, out_ready=0 and a beat arrives, it goes to skid. Skid moves to main on the next transfer-out. Capacity 2 beats. Order is preserved. Flush clears both entries.
- Not defined: no skid storage, capacity 1, in_ready combinational as above.

## Test plan
- Reset low mid-stream with out_valid=1 → all outputs 0 immediately, in_ready=1 after release.
- Stream 4 beats (alu 0x10..0x13, wr_reg 1..4, ctrl=01), out_ready=1 → out_wb_data 0x10..0x13 on consecutive cycles, fwd_valid=1 each cycle.
- Beat with ctrl=11, mem 0xDEADBEEF, alu 0x4 → out_wb_data=0xDEADBEEF. Beat with wr_reg=0, ctrl=01 → out_ctrl[0]=0, fwd_valid=0.
- out_ready=0 for 3 cycles while in_valid=1 → without macro, in_ready=0 after first beat. With PIPE_WB_SKID_EN, two beats held, in_ready=0 after second, both beats delivered in order on release.
- flush=1 with main (and skid) full and in_valid=1 → next cycle out_valid=0, out_ctrl=0, no beat later emerges.
- Simultaneous transfer-in and transfer-out every cycle for 8 cycles → out_valid stays 1, each beat appears exactly once.
